parking_gate_controller: RTL and testbench

- Sequencing controller for the parking lot's single shared gate.
- Latches entry and exit requests from the lane sensors and arbitrates between them, since both lanes share one door.
- Allocates or frees slots in a registered occupancy map and times the door-open window.
- Drives the slot map, capacity, best-place and full indications consumed by the display/top-level circuit.

---
 rtl/parking_gate_controller.sv | 195 +++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Shared-gate sequencer: latches entry/exit requests, arbitrates round-robin, keeps the slot map and times the door.
// Optional macro RESERVE_SLOT_EN reserves the top slot for VIP entries (adds the entry_vip input).
module parking_gate_controller #(
    parameter int NUM_SLOTS   = 4,
    parameter int OPEN_CYCLES = 8,
    parameter int SLOT_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
`ifdef RESERVE_SLOT_EN
    input  logic                 entry_vip,
`endif
    output logic                 entry_grant,
    output logic                 exit_grant,
    output logic                 reject,
    output logic                 door_open,
    output logic [NUM_SLOTS-1:0] parking_slots,
    output logic                 full_light,
    output logic [2:0]           capacity,
    output logic [2:0]           best_place
);

    localparam int TW = (OPEN_CYCLES < 2) ? 1 : $clog2(OPEN_CYCLES + 1);
`ifdef RESERVE_SLOT_EN
    localparam int GEN_SLOTS = NUM_SLOTS - 1;
`else
    localparam int GEN_SLOTS = NUM_SLOTS;
`endif

    typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSE} state_t;

    state_t                state, state_d;
    logic [TW-1:0]         timer, timer_d;
    logic [NUM_SLOTS-1:0]  slots_d;
    logic                  ptr_exit, ptr_exit_d;
    logic                  entry_pend, exit_pend;
    logic [SLOT_W-1:0]     exit_slot_q;
    logic                  clr_entry, clr_exit;
    logic                  entry_grant_d, exit_grant_d, reject_d;
    logic                  serve_exit;
    logic [NUM_SLOTS-1:0]  gen_mask, entry_mask, exit_mask;
    logic                  gen_free, entry_full, exit_ok;
    logic [2:0]            free_cnt, gen_best;
`ifdef RESERVE_SLOT_EN
    logic                  vip_q;
    logic [NUM_SLOTS-1:0]  all_mask;
    logic                  all_free;
`endif

    // Slot bookkeeping: free count over all slots, lowest free slot over the general pool.
    always_comb begin
        free_cnt = 3'd0;
        gen_mask = '0;
        gen_free = 1'b0;
        gen_best = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!parking_slots[i]) begin
                free_cnt = free_cnt + 3'd1;
                if (i < GEN_SLOTS) begin
                    gen_mask    = '0;
                    gen_mask[i] = 1'b1;
                    gen_free    = 1'b1;
                    gen_best    = 3'(i + 1);
                end
            end
        end
`ifdef RESERVE_SLOT_EN
        all_mask = '0;
        all_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!parking_slots[i]) begin
                all_mask    = '0;
                all_mask[i] = 1'b1;
                all_free    = 1'b1;
            end
        end
        entry_mask = vip_q ? all_mask : gen_mask;
        entry_full = vip_q ? !all_free : !gen_free;
`else
        entry_mask = gen_mask;
        entry_full = !gen_free;
`endif
        exit_mask = '0;
        exit_ok   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (exit_slot_q == SLOT_W'(i)) begin
                exit_mask[i] = 1'b1;
                exit_ok      = parking_slots[i];
            end
        end
    end

    assign capacity   = free_cnt;
    assign best_place = gen_best;
    assign full_light = !gen_free;
    assign door_open  = (state == ENTRY_OPEN) || (state == EXIT_OPEN);

    always_comb begin
        state_d       = state;
        timer_d       = timer;
        slots_d       = parking_slots;
        ptr_exit_d    = ptr_exit;
        clr_entry     = 1'b0;
        clr_exit      = 1'b0;
        entry_grant_d = 1'b0;
        exit_grant_d  = 1'b0;
        reject_d      = 1'b0;
        serve_exit    = 1'b0;
        case (state)
            IDLE: begin
                if (entry_pend || exit_pend) begin
                    // Contended: pointer picks the winner, then points at the loser.
                    serve_exit = exit_pend && (!entry_pend || ptr_exit);
                    if (entry_pend && exit_pend) ptr_exit_d = !ptr_exit;
                    if (serve_exit) begin
                        clr_exit = 1'b1;
                        if (exit_ok) begin
                            slots_d      = parking_slots & ~exit_mask;
                            exit_grant_d = 1'b1;
                            timer_d      = TW'(OPEN_CYCLES);
                            state_d      = EXIT_OPEN;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else begin
                        clr_entry = 1'b1;
                        if (entry_full) begin
                            reject_d = 1'b1;
                        end else begin
                            slots_d       = parking_slots | entry_mask;
                            entry_grant_d = 1'b1;
                            timer_d       = TW'(OPEN_CYCLES);
                            state_d       = ENTRY_OPEN;
                        end
                    end
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (timer <= TW'(1)) begin
                    timer_d = '0;
                    state_d = CLOSE;
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            CLOSE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            parking_slots <= '0;
            ptr_exit      <= 1'b1;
            entry_pend    <= 1'b0;
            exit_pend     <= 1'b0;
            exit_slot_q   <= '0;
            entry_grant   <= 1'b0;
            exit_grant    <= 1'b0;
            reject        <= 1'b0;
`ifdef RESERVE_SLOT_EN
            vip_q         <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            parking_slots <= slots_d;
            ptr_exit      <= ptr_exit_d;
            entry_grant   <= entry_grant_d;
            exit_grant    <= exit_grant_d;
            reject        <= reject_d;
            // A pulse arriving while its flag is still pending is dropped.
            if (clr_entry) begin
                entry_pend <= 1'b0;
            end else if (entry_req && !entry_pend) begin
                entry_pend <= 1'b1;
`ifdef RESERVE_SLOT_EN
                vip_q      <= entry_vip;
`endif
            end
            if (clr_exit) begin
                exit_pend <= 1'b0;
            end else if (exit_req && !exit_pend) begin
                exit_pend   <= 1'b1;
                exit_slot_q <= exit_slot;
            end
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed scenarios plus random request traffic,
// checked by a scoreboard fed from a cycle-level behavioural model of the gate.
module tb_parking_gate_controller;

    localparam int NUM_SLOTS   = 4;
    localparam int OPEN_CYCLES = 8;
    localparam int SLOT_W      = 2;
    localparam int W           = 3 + NUM_SLOTS;

    localparam logic [2:0] K_ENTRY  = 3'b100;
    localparam logic [2:0] K_EXIT   = 3'b010;
    localparam logic [2:0] K_REJECT = 3'b001;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 entry_req = 1'b0;
    logic                 exit_req = 1'b0;
    logic [SLOT_W-1:0]    exit_slot = '0;
    logic                 entry_grant, exit_grant, reject, door_open, full_light;
    logic [NUM_SLOTS-1:0] parking_slots;
    logic [2:0]           capacity, best_place;

    parking_gate_controller #(
        .NUM_SLOTS(NUM_SLOTS), .OPEN_CYCLES(OPEN_CYCLES), .SLOT_W(SLOT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .entry_grant(entry_grant), .exit_grant(exit_grant),
        .reject(reject), .door_open(door_open), .parking_slots(parking_slots),
        .full_light(full_light), .capacity(capacity), .best_place(best_place)
    );

    always #5 clk = ~clk;

    // Scoreboard: {event kind, slot map after the event}, plus expected door level per cycle.
    logic [W-1:0] exp_q[$];
    logic         door_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;

    // Reference model state: pending requests, occupancy, arbitration turn, door timing.
    logic [NUM_SLOTS-1:0] m_slots;
    bit                   m_ep, m_xp, m_exit_turn, m_closing;
    int                   m_xs, m_door_left;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_free(input logic [NUM_SLOTS-1:0] s);
        for (int i = 0; i < NUM_SLOTS; i++)
            if (!s[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_slots = '0; m_ep = 0; m_xp = 0; m_xs = 0;
        m_exit_turn = 1; m_door_left = 0; m_closing = 0;
        exp_q.delete();
        door_q.delete();
    endtask

    // One clock edge of the gate, evaluated from the rules, with the inputs present at that edge.
    task automatic model_step(input bit e, input bit x, input int s);
        bit ep_old = m_ep;
        bit xp_old = m_xp;
        bit srv_e = 0;
        bit srv_x = 0;
        int idx;
        if (m_door_left > 0) begin
            m_door_left--;
            if (m_door_left == 0) m_closing = 1;
        end else if (m_closing) begin
            m_closing = 0;
        end else if (m_ep || m_xp) begin
            if (m_ep && m_xp) begin
                srv_x = m_exit_turn;
                srv_e = !m_exit_turn;
                m_exit_turn = !m_exit_turn;
            end else begin
                srv_x = m_xp;
                srv_e = m_ep;
            end
            if (srv_x) begin
                if (m_xs < NUM_SLOTS && m_slots[m_xs]) begin
                    m_slots[m_xs] = 1'b0;
                    exp_q.push_back({K_EXIT, m_slots});
                    m_door_left = OPEN_CYCLES;
                end else begin
                    exp_q.push_back({K_REJECT, m_slots});
                end
            end else begin
                idx = lowest_free(m_slots);
                if (idx < 0) begin
                    exp_q.push_back({K_REJECT, m_slots});
                end else begin
                    m_slots[idx] = 1'b1;
                    exp_q.push_back({K_ENTRY, m_slots});
                    m_door_left = OPEN_CYCLES;
                end
            end
        end
        m_ep = ep_old ? !srv_e : e;
        if (xp_old) begin
            m_xp = !srv_x;
        end else begin
            m_xp = x;
            if (x) m_xs = s;
        end
        door_q.push_back(m_door_left > 0);
    endtask

    // Monitor: pops the expected door level every cycle and an event whenever a pulse appears.
    logic [W-1:0] mon_item;
    int           mon_lf;
    always @(negedge clk) begin
        if (rst_n) begin
            if (door_q.size() > 0) check("door_open", int'(door_open), int'(door_q.pop_front()));
            if (entry_grant || exit_grant || reject) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({entry_grant, exit_grant, reject}), 0);
                end else begin
                    mon_item = exp_q.pop_front();
                    mon_lf = lowest_free(mon_item[NUM_SLOTS-1:0]);
                    check("event_kind", int'({entry_grant, exit_grant, reject}), int'(mon_item[W-1:NUM_SLOTS]));
                    check("parking_slots", int'(parking_slots), int'(mon_item[NUM_SLOTS-1:0]));
                    check("capacity", int'(capacity), NUM_SLOTS - $countones(mon_item[NUM_SLOTS-1:0]));
                    check("best_place", int'(best_place), mon_lf + 1);
                    check("full_light", int'(full_light), (mon_lf < 0) ? 1 : 0);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_slots"}, int'(parking_slots), 0);
        check({tag, "_capacity"}, int'(capacity), NUM_SLOTS);
        check({tag, "_best_place"}, int'(best_place), 1);
        check({tag, "_full_light"}, int'(full_light), 0);
        check({tag, "_door_open"}, int'(door_open), 0);
        check({tag, "_pulses"}, int'({entry_grant, exit_grant, reject}), 0);
    endtask

    // Called and returning in the negedge phase.
    task automatic do_reset();
        rst_n = 1'b0;
        entry_req = 1'b0;
        exit_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_cycle(input bit e, input bit x, input int s);
        entry_req = e;
        exit_req = x;
        exit_slot = SLOT_W'(s);
        @(posedge clk);
        model_step(e, x, s);
        @(negedge clk);
        entry_req = 1'b0;
        exit_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_ep || m_xp || m_door_left > 0 || m_closing) && n < 60) begin
            drive_cycle(0, 0, 0);
            n++;
        end
        if (n >= 60) check("wait_idle_timeout", n, 0);
        drive_cycle(0, 0, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        check_reset_values("reset");

        // Single entry, then fill the lot and overflow it.
        drive_cycle(1, 0, 0);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 0, 0);
            wait_idle();
        end
        check("full_slots", int'(parking_slots), 15);

        // Exit from slot 1, then the same slot again.
        drive_cycle(0, 1, 1);
        wait_idle();
        drive_cycle(0, 1, 1);
        wait_idle();
        check("after_exit_slots", int'(parking_slots), 13);

        // Simultaneous pairs from reset: exit wins first, then the entry side.
        do_reset();
        drive_cycle(1, 1, 0);
        wait_idle();
        drive_cycle(1, 1, 0);
        wait_idle();
        check("pair_slots", int'(parking_slots), 2);

        // Reset while the door is open with an exit waiting.
        drive_cycle(1, 0, 0);
        for (int i = 0; i < 6 && !door_open; i++) drive_cycle(0, 0, 0);
        check("door_opened_before_reset", int'(door_open), 1);
        drive_cycle(0, 1, 1);
        drive_cycle(0, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midop_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) drive_cycle(0, 0, 0);
        check("after_midop_reset_slots", int'(parking_slots), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            drive_cycle($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, int'($urandom_range(0, NUM_SLOTS - 1)));
        wait_idle();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
